// File: rtl/bcd4_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter.
// Consumes one digit per clock, thousands first, using acc*10 + digit.
module bcd4_to_bin #(
  parameter logic [3:0] BLANK_CODE    = 4'hF,
  parameter bit         BLANK_IS_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic [3:0]  C,
  input  logic [3:0]  D,
  output logic [13:0] value,
  output logic        ready,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] shift_reg;
  logic [13:0] acc_reg;
  logic [1:0]  cnt_reg;
  logic        err_acc_reg;

  logic [3:0]  dig;
  logic        dig_valid;
  logic        dig_blank;
  logic        dig_bad;
  logic [3:0]  dig_eff;
  logic [13:0] acc_next;

  // Invalid digits contribute 0, so the result can never exceed 9999.
  always_comb begin
    dig       = shift_reg[15:12];
    dig_valid = (dig <= 4'd9);
    dig_blank = (dig == BLANK_CODE) && (BLANK_IS_ZERO != 1'b0);
    dig_bad   = !dig_valid && !dig_blank;
    dig_eff   = dig_valid ? dig : 4'd0;
    acc_next  = (acc_reg << 3) + (acc_reg << 1) + {10'd0, dig_eff};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ACCUM;
      S_ACCUM: if (cnt_reg == 2'd3) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_reg == S_IDLE);
    done  = (state_reg == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= 16'd0;
      acc_reg     <= 14'd0;
      cnt_reg     <= 2'd0;
      err_acc_reg <= 1'b0;
      value       <= 14'd0;
      error       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            shift_reg   <= {D, C, B, A};
            acc_reg     <= 14'd0;
            cnt_reg     <= 2'd0;
            err_acc_reg <= 1'b0;
          end
        end
        S_ACCUM: begin
          acc_reg     <= acc_next;
          shift_reg   <= {shift_reg[11:0], 4'd0};
          cnt_reg     <= cnt_reg + 2'd1;
          err_acc_reg <= err_acc_reg | dig_bad;
          if (cnt_reg == 2'd3) begin
            value <= acc_next;
            error <= err_acc_reg | dig_bad;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd4_to_bin.sv
// Bench for bcd4_to_bin: a timeline/arithmetic model checked every cycle,
// plus directed conversions with hand-computed results.
module tb_bcd4_to_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  A, B, C, D;
  logic [13:0] value, value_s;
  logic        ready, done, error;
  logic        ready_s, done_s, error_s;

  int checks = 0;
  int errors = 0;

  bcd4_to_bin #(.BLANK_CODE(4'hF), .BLANK_IS_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C), .D(D),
    .value(value), .ready(ready), .done(done), .error(error)
  );

  bcd4_to_bin #(.BLANK_CODE(4'hF), .BLANK_IS_ZERO(1'b0)) dut_strict (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C), .D(D),
    .value(value_s), .ready(ready_s), .done(done_s), .error(error_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of the digits by place weight; non-decimal codes count as 0.
  function automatic int conv_val(input logic [3:0] d, c, b, a);
    int w[4];
    logic [3:0] dg[4];
    int v;
    w = '{1000, 100, 10, 1};
    dg = '{d, c, b, a};
    v = 0;
    for (int i = 0; i < 4; i++)
      if (dg[i] <= 4'd9) v += int'(dg[i]) * w[i];
    return v;
  endfunction

  function automatic bit conv_err(input logic [3:0] d, c, b, a, input bit blank_zero);
    logic [3:0] dg[4];
    bit e;
    dg = '{d, c, b, a};
    e = 1'b0;
    for (int i = 0; i < 4; i++)
      if (dg[i] > 4'd9 && !(dg[i] == 4'hF && blank_zero)) e = 1'b1;
    return e;
  endfunction

  // Model timeline: phase 0 idle, 1..4 accumulating, 5 done.
  int m_phase, m_val, p_val;
  bit m_err, m_err_s, p_err, p_err_s;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_val   <= 0;
      m_err   <= 1'b0;
      m_err_s <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          p_val   <= conv_val(D, C, B, A);
          p_err   <= conv_err(D, C, B, A, 1'b1);
          p_err_s <= conv_err(D, C, B, A, 1'b0);
        end
        1, 2, 3: m_phase <= m_phase + 1;
        4: begin
          m_phase <= 5;
          m_val   <= p_val;
          m_err   <= p_err;
          m_err_s <= p_err_s;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("ready", int'(ready), int'(m_phase == 0));
    chk("done", int'(done), int'(m_phase == 5));
    chk("value", int'(value), m_val);
    chk("error", int'(error), int'(m_err));
    chk("ready_strict", int'(ready_s), int'(m_phase == 0));
    chk("value_strict", int'(value_s), m_val);
    chk("error_strict", int'(error_s), int'(m_err_s));
  end

  task automatic convert(input logic [3:0] d, c, b, a, input int exp_v,
                         input bit exp_e, input bit exp_es, input string tag);
    int cyc;
    @(negedge clk);
    D = d; C = c; B = b; A = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ready_busy"}, int'(ready), 0);
    cyc = 0;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_value"}, int'(value), exp_v);
    chk({tag, "_error"}, int'(error), int'(exp_e));
    chk({tag, "_error_strict"}, int'(error_s), int'(exp_es));
    @(negedge clk);
    chk({tag, "_ready_after"}, int'(ready), 1);
    chk({tag, "_done_after"}, int'(done), 0);
  endtask

  initial begin
    int ndone;
    rst = 1'b0; start = 1'b0;
    A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;

    repeat (2) @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    start = 1'b1; A = 4'd9; B = 4'd9; C = 4'd9; D = 4'd9;
    repeat (3) @(negedge clk);
    chk("rst_hold_value", int'(value), 0);
    chk("rst_hold_ready", int'(ready), 1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    convert(4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0, 1'b0, "t1234");
    convert(4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0, 1'b0, "t9999");
    convert(4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0, 1'b0, "t0000");
    convert(4'hF, 4'hF, 4'd4, 4'd2, 42,   1'b0, 1'b1, "tblank");
    convert(4'd1, 4'd1, 4'hC, 4'd1, 1101, 1'b1, 1'b1, "tinval");

    // Start and digit changes while busy must be ignored.
    @(negedge clk);
    D = 4'd5; C = 4'd6; B = 4'd7; A = 4'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    D = 4'd9; C = 4'd9; B = 4'd9; A = 4'd9;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (i == 0);
    end
    chk("busy_done_count", ndone, 1);
    chk("busy_value", int'(value), 5678);

    // Start held high: one conversion every 6 cycles.
    @(negedge clk);
    D = 4'd0; C = 4'd0; B = 4'd4; A = 4'd2;
    start = 1'b1;
    ndone = 0;
    repeat (18) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("held_done_count", ndone, 3);
    repeat (8) @(negedge clk);
    chk("held_value", int'(value), 42);

    // Reset during the second accumulate cycle.
    @(negedge clk);
    D = 4'd1; C = 4'd2; B = 4'd3; A = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_value", int'(value), 0);
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    @(negedge clk);
    rst = 1'b1;
    convert(4'd0, 4'd0, 4'd4, 4'd2, 42, 1'b0, 1'b0, "tafter");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
